// File: rtl/switching_activity_counter_if.sv
// Sample/result bundle for switching_activity_counter.
// The per-channel sample-count bus exists only when SAC_SAMPLE_CNT_EN is defined.
interface switching_activity_counter_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic [3:0]       d;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [CNT_W-1:0] cnt3;
    logic [3:0]       ovf;
    logic             res_valid;
    logic             res_ready;
`ifdef SAC_SAMPLE_CNT_EN
    logic [4*CNT_W-1:0] smp_cnt;

    modport master (
        output in_valid, sel, d, res_ready,
        input  in_ready, cnt0, cnt1, cnt2, cnt3, ovf, res_valid, smp_cnt
    );
    modport slave (
        input  in_valid, sel, d, res_ready,
        output in_ready, cnt0, cnt1, cnt2, cnt3, ovf, res_valid, smp_cnt
    );
`else
    modport master (
        output in_valid, sel, d, res_ready,
        input  in_ready, cnt0, cnt1, cnt2, cnt3, ovf, res_valid
    );
    modport slave (
        input  in_valid, sel, d, res_ready,
        output in_ready, cnt0, cnt1, cnt2, cnt3, ovf, res_valid
    );
`endif
endinterface

// File: rtl/switching_activity_counter.sv
// Per-channel toggle counter over fixed windows of accepted demux samples.
// Optional per-channel sample counts are enabled by defining SAC_SAMPLE_CNT_EN.
module switching_activity_counter #(
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 256
) (
    input logic                    clk,
    input logic                    rst,
    switching_activity_counter_if.slave bus
);
    localparam int SW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [SW-1:0] LAST_IDX = SW'(WIN_LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tog     [4];
    logic [CNT_W-1:0] tog_nxt [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [3:0]       ovf_int, ovf_int_nxt, ovf_q;
    logic [3:0]       seen, last;
    logic [SW-1:0]    smp_cnt;
    logic             res_valid_q;
    logic             in_ready, accept, b, win_end;

    assign b       = bus.d[bus.sel];
    assign accept  = bus.in_valid & in_ready;
    assign win_end = accept && (smp_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (win_end) state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) state_nxt = ACCUM;
            end
        endcase
    end

    // A toggle at saturation only raises the overflow flag for that channel.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) tog_nxt[i] = tog[i];
        ovf_int_nxt = ovf_int;
        if (accept && seen[bus.sel] && (b != last[bus.sel])) begin
            if (tog[bus.sel] == '1) ovf_int_nxt[bus.sel] = 1'b1;
            else                    tog_nxt[bus.sel]     = tog[bus.sel] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tog         <= '{default: '0};
            cnt_q       <= '{default: '0};
            ovf_int     <= '0;
            ovf_q       <= '0;
            seen        <= '0;
            last        <= '0;
            smp_cnt     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                seen[bus.sel] <= 1'b1;
                last[bus.sel] <= b;
            end
            if (win_end) begin
                cnt_q       <= tog_nxt;
                ovf_q       <= ovf_int_nxt;
                res_valid_q <= 1'b1;
                tog         <= '{default: '0};
                ovf_int     <= '0;
                smp_cnt     <= '0;
            end else begin
                tog     <= tog_nxt;
                ovf_int <= ovf_int_nxt;
                if (accept) smp_cnt <= smp_cnt + 1'b1;
                if (state == HOLD && bus.res_ready) res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.cnt0      = cnt_q[0];
    assign bus.cnt1      = cnt_q[1];
    assign bus.cnt2      = cnt_q[2];
    assign bus.cnt3      = cnt_q[3];
    assign bus.ovf       = ovf_q;

`ifdef SAC_SAMPLE_CNT_EN
    logic [CNT_W-1:0] chs     [4];
    logic [CNT_W-1:0] chs_nxt [4];
    logic [CNT_W-1:0] chs_q   [4];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) chs_nxt[i] = chs[i];
        if (accept && (chs[bus.sel] != '1)) chs_nxt[bus.sel] = chs[bus.sel] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chs   <= '{default: '0};
            chs_q <= '{default: '0};
        end else if (win_end) begin
            chs_q <= chs_nxt;
            chs   <= '{default: '0};
        end else begin
            chs <= chs_nxt;
        end
    end

    assign bus.smp_cnt = {chs_q[3], chs_q[2], chs_q[1], chs_q[0]};
`endif
endmodule
